// File: rtl/crc_rx_checker_if.sv
// Word stream and verdict bundle between the RX deserializer, the CRC
// checker and the RX message buffer.
interface crc_rx_checker_if #(
  parameter int CNT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  logic             result_valid;
  logic             crc_ok;
  logic             crc_err;
  logic [15:0]      crc_calc;
  logic [CNT_W-1:0] err_count;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, result_valid, crc_ok, crc_err, crc_calc, err_count
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, result_valid, crc_ok, crc_err, crc_calc, err_count
  );
endinterface

// File: rtl/crc_rx_checker.sv
// Receive-side CRC-16 (poly 0xC599, init 0xFFFF) checker: folds each 32-bit
// payload word MSB-first, BITS_PER_CYCLE bits per clock, then judges the CRC word.
module crc_rx_checker #(
  parameter int BITS_PER_CYCLE = 8,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_abort,
  crc_rx_checker_if.slave    bus
);
  localparam int          N      = 32 / BITS_PER_CYCLE;
  localparam logic [15:0] C_POLY = 16'hC599;
  localparam logic [15:0] C_INIT = 16'hFFFF;

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 &&
      BITS_PER_CYCLE != 8 && BITS_PER_CYCLE != 16 && BITS_PER_CYCLE != 32) begin : g_bad_bpc
    $error("crc_rx_checker: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    DATA     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_CRC = 2'd2,
    REPORT   = 2'd3
  } state_t;

  state_t           r_state;
  logic [15:0]      r_crc;
  logic [15:0]      r_crc_calc;
  logic [31:0]      r_shift;
  logic             r_last;
  logic [5:0]       r_cnt;
  logic             r_ready;
  logic             r_result_valid;
  logic             r_crc_ok;
  logic             r_crc_err;
  logic [CNT_W-1:0] r_err_count;
  logic             w_accept;
  logic             w_match;
  logic [15:0]      w_crc_next;

  // Galois-shift the CRC over a chunk of bits, chunk MSB first.
  function automatic logic [15:0] crc_fold(input logic [15:0] crc_in,
                                           input logic [BITS_PER_CYCLE-1:0] bits);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? C_POLY : 16'h0000);
    end
    return c;
  endfunction

  // Abort masks ready combinationally so a coincident word is never taken.
  assign bus.s_ready      = r_ready & ~i_abort;
  assign w_accept         = bus.s_valid & bus.s_ready;
  assign w_match          = (bus.s_data[15:0] == r_crc);
  assign w_crc_next       = crc_fold(r_crc, r_shift[31 -: BITS_PER_CYCLE]);
  assign bus.result_valid = r_result_valid;
  assign bus.crc_ok       = r_crc_ok;
  assign bus.crc_err      = r_crc_err;
  assign bus.crc_calc     = r_crc_calc;
  assign bus.err_count    = r_err_count;

  // Frame FSM with registered handshake and verdict outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= DATA;
      r_crc          <= C_INIT;
      r_crc_calc     <= C_INIT;
      r_shift        <= 32'h0000_0000;
      r_last         <= 1'b0;
      r_cnt          <= 6'd0;
      r_ready        <= 1'b1;
      r_result_valid <= 1'b0;
      r_crc_ok       <= 1'b0;
      r_crc_err      <= 1'b0;
      r_err_count    <= '0;
    end else if (i_abort && r_state != REPORT) begin
      r_state        <= DATA;
      r_crc          <= C_INIT;
      r_ready        <= 1'b1;
      r_result_valid <= 1'b0;
      r_crc_ok       <= 1'b0;
      r_crc_err      <= 1'b0;
    end else begin
      case (r_state)
        DATA: begin
          if (w_accept) begin
            r_shift <= bus.s_data;
            r_last  <= bus.s_last;
            r_cnt   <= 6'(N);
            r_ready <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_crc   <= w_crc_next;
          r_shift <= r_shift << BITS_PER_CYCLE;
          r_cnt   <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_ready <= 1'b1;
            r_state <= r_last ? WAIT_CRC : DATA;
          end
        end
        WAIT_CRC: begin
          if (w_accept) begin
            r_result_valid <= 1'b1;
            r_crc_ok       <= w_match;
            r_crc_err      <= ~w_match;
            r_crc_calc     <= r_crc;
            if (!w_match && r_err_count != {CNT_W{1'b1}}) begin
              r_err_count <= r_err_count + CNT_W'(1);
            end
            r_ready <= 1'b0;
            r_state <= REPORT;
          end
        end
        REPORT: begin
          r_result_valid <= 1'b0;
          r_crc_ok       <= 1'b0;
          r_crc_err      <= 1'b0;
          r_crc          <= C_INIT;
          r_ready        <= 1'b1;
          r_state        <= DATA;
        end
        default: begin
          r_result_valid <= 1'b0;
          r_crc_ok       <= 1'b0;
          r_crc_err      <= 1'b0;
          r_crc          <= C_INIT;
          r_ready        <= 1'b1;
          r_state        <= DATA;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crc_rx_checker.sv
// Directed bench for crc_rx_checker: three instances (8, 1 and 32 bits per
// cycle, the last with a 2-bit error counter) driven one at a time.
module tb_crc_rx_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        tb_valid;
  logic        tb_last;
  logic        tb_abort;
  logic [31:0] tb_data;
  int          checks;
  int          errors;

  logic        w_ready;
  logic        w_rv;
  logic        w_ok;
  logic        w_err;
  logic [15:0] w_calc;
  logic [15:0] w_cnt;

  crc_rx_checker_if #(.CNT_W(16)) if8 ();
  crc_rx_checker_if #(.CNT_W(16)) if1 ();
  crc_rx_checker_if #(.CNT_W(2))  if32 ();

  assign if8.s_valid  = tb_valid && (sel == 2'd0);
  assign if1.s_valid  = tb_valid && (sel == 2'd1);
  assign if32.s_valid = tb_valid && (sel == 2'd2);
  assign if8.s_data   = tb_data;
  assign if1.s_data   = tb_data;
  assign if32.s_data  = tb_data;
  assign if8.s_last   = tb_last;
  assign if1.s_last   = tb_last;
  assign if32.s_last  = tb_last;

  crc_rx_checker #(.BITS_PER_CYCLE(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .i_abort(tb_abort), .bus(if8.slave));
  crc_rx_checker #(.BITS_PER_CYCLE(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .i_abort(tb_abort), .bus(if1.slave));
  crc_rx_checker #(.BITS_PER_CYCLE(32), .CNT_W(2)) u_dut32 (
    .clk(clk), .rst(rst), .i_abort(tb_abort), .bus(if32.slave));

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      2'd1: begin
        w_ready = if1.s_ready; w_rv = if1.result_valid; w_ok = if1.crc_ok;
        w_err = if1.crc_err; w_calc = if1.crc_calc; w_cnt = if1.err_count;
      end
      2'd2: begin
        w_ready = if32.s_ready; w_rv = if32.result_valid; w_ok = if32.crc_ok;
        w_err = if32.crc_err; w_calc = if32.crc_calc; w_cnt = {14'd0, if32.err_count};
      end
      default: begin
        w_ready = if8.s_ready; w_rv = if8.result_valid; w_ok = if8.crc_ok;
        w_err = if8.crc_err; w_calc = if8.crc_calc; w_cnt = if8.err_count;
      end
    endcase
  end

  // Stimulus only: payload 0x00000000 (last) then crcw; captures the cycle after the CRC handshake.
  task automatic run_frame(input logic [31:0] crcw, output int shift_len, output logic got,
                           output logic ok, output logic err, output logic [15:0] calc,
                           output logic [15:0] cnt, output logic tmo);
    int w;
    tmo = 1'b0;
    @(negedge clk);
    tb_data = 32'h0000_0000; tb_last = 1'b1; tb_valid = 1'b1;
    w = 0;
    while (!w_ready && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) tmo = 1'b1;
    @(posedge clk); #1; tb_valid = 1'b0;
    @(negedge clk);
    shift_len = 0;
    while (!w_ready && shift_len < 100) begin shift_len++; @(negedge clk); end
    if (shift_len >= 100) tmo = 1'b1;
    tb_data = crcw; tb_last = 1'b0; tb_valid = 1'b1;
    @(posedge clk); #1; tb_valid = 1'b0;
    @(negedge clk);
    got = w_rv; ok = w_ok; err = w_err; calc = w_calc; cnt = w_cnt;
  endtask

  task automatic test_reset();
    sel = 2'd0; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", w_ready); end
    checks++; if (w_rv !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b expected 0", w_rv); end
    checks++; if ({w_ok, w_err} !== 2'b00) begin errors++; $display("FAIL reset_okerr: got %b expected 00", {w_ok, w_err}); end
    checks++; if (w_calc !== 16'hFFFF) begin errors++; $display("FAIL reset_calc: got %h expected ffff", w_calc); end
    checks++; if (w_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", w_cnt); end
  endtask

  task automatic test_good();
    int sl; logic g, ok, er, tmo; logic [15:0] calc, cnt;
    sel = 2'd0;
    run_frame(32'h0000_046A, sl, g, ok, er, calc, cnt, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL good_timeout: got %b expected 0", tmo); end
    checks++; if (sl !== 4) begin errors++; $display("FAIL good_shift_len: got %0d expected 4", sl); end
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL good_rv: got %b expected 1", g); end
    checks++; if ({ok, er} !== 2'b10) begin errors++; $display("FAIL good_okerr: got %b expected 10", {ok, er}); end
    checks++; if (calc !== 16'h046A) begin errors++; $display("FAIL good_calc: got %h expected 046a", calc); end
    checks++; if (cnt !== 16'h0000) begin errors++; $display("FAIL good_cnt: got %h expected 0000", cnt); end
    @(negedge clk);
    checks++; if ({w_rv, w_ok, w_err} !== 3'b000) begin errors++; $display("FAIL good_pulse_end: got %b expected 000", {w_rv, w_ok, w_err}); end
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL good_ready_after: got %b expected 1", w_ready); end
  endtask

  task automatic test_bad();
    int sl; logic g, ok, er, tmo; logic [15:0] calc, cnt;
    sel = 2'd0;
    run_frame(32'hABCD_046B, sl, g, ok, er, calc, cnt, tmo);
    checks++; if ({tmo, g} !== 2'b01) begin errors++; $display("FAIL bad_rv: got %b expected 01", {tmo, g}); end
    checks++; if ({ok, er} !== 2'b01) begin errors++; $display("FAIL bad_okerr: got %b expected 01", {ok, er}); end
    checks++; if (calc !== 16'h046A) begin errors++; $display("FAIL bad_calc: got %h expected 046a", calc); end
    checks++; if (cnt !== 16'h0001) begin errors++; $display("FAIL bad_cnt: got %h expected 0001", cnt); end
    run_frame(32'hFFFF_046A, sl, g, ok, er, calc, cnt, tmo);
    checks++; if ({tmo, g, ok, er} !== 4'b0110) begin errors++; $display("FAIL upper_ignored: got %b expected 0110", {tmo, g, ok, er}); end
    checks++; if (cnt !== 16'h0001) begin errors++; $display("FAIL upper_cnt: got %h expected 0001", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4];
    logic        lst [4];
    int idx, low, nres, nok;
    seq[0] = 32'h0000_0000; seq[1] = 32'h0000_046A; seq[2] = 32'h0000_0000; seq[3] = 32'h0000_046A;
    lst[0] = 1'b1; lst[1] = 1'b0; lst[2] = 1'b1; lst[3] = 1'b0;
    sel = 2'd0; idx = 0; low = 0; nres = 0; nok = 0;
    @(negedge clk);
    tb_data = seq[0]; tb_last = lst[0]; tb_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && idx < 4; cyc++) begin
      if (w_rv) begin nres++; if (w_ok && !w_err && w_calc == 16'h046A) nok++; end
      if (w_ready) begin
        @(posedge clk); #1; idx++;
        if (idx < 4) begin tb_data = seq[idx]; tb_last = lst[idx]; end
      end else begin
        low++;
      end
      @(negedge clk);
    end
    tb_valid = 1'b0;
    if (w_rv) begin nres++; if (w_ok && !w_err && w_calc == 16'h046A) nok++; end
    if (!w_ready) low++;
    checks++; if (idx !== 4) begin errors++; $display("FAIL b2b_handshakes: got %0d expected 4", idx); end
    checks++; if (nres !== 2) begin errors++; $display("FAIL b2b_reports: got %0d expected 2", nres); end
    checks++; if (nok !== 2) begin errors++; $display("FAIL b2b_ok: got %0d expected 2", nok); end
    checks++; if (low !== 10) begin errors++; $display("FAIL b2b_ready_low: got %0d expected 10", low); end
  endtask

  task automatic test_abort();
    int sl, w; logic g, ok, er, tmo; logic [15:0] calc, cnt;
    sel = 2'd0;
    @(negedge clk);
    tb_data = 32'h1234_5678; tb_last = 1'b0; tb_valid = 1'b1;
    w = 0;
    while (!w_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1; tb_valid = 1'b0;
    @(negedge clk);
    tb_abort = 1'b1;
    @(posedge clk); #1; tb_abort = 1'b0;
    @(negedge clk);
    checks++; if ({w_ready, w_rv} !== 2'b10) begin errors++; $display("FAIL abort_shift: got %b expected 10", {w_ready, w_rv}); end
    checks++; if ({w_calc, w_cnt} !== {16'h046A, 16'h0001}) begin errors++; $display("FAIL abort_keep: got %h expected 046a0001", {w_calc, w_cnt}); end
    tb_data = 32'h0000_0000; tb_last = 1'b1; tb_valid = 1'b1; tb_abort = 1'b1;
    #1;
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_mask: got %b expected 0", w_ready); end
    @(posedge clk); #1; tb_valid = 1'b0; tb_abort = 1'b0;
    @(negedge clk);
    checks++; if ({w_ready, w_rv} !== 2'b10) begin errors++; $display("FAIL abort_no_accept: got %b expected 10", {w_ready, w_rv}); end
    run_frame(32'h0000_046A, sl, g, ok, er, calc, cnt, tmo);
    checks++; if ({tmo, g, ok, er} !== 4'b0110) begin errors++; $display("FAIL abort_fresh: got %b expected 0110", {tmo, g, ok, er}); end
    checks++; if (calc !== 16'h046A) begin errors++; $display("FAIL abort_fresh_calc: got %h expected 046a", calc); end
  endtask

  task automatic test_mid_reset();
    int sl, w; logic g, ok, er, tmo; logic [15:0] calc, cnt;
    sel = 2'd0;
    @(negedge clk);
    tb_data = 32'hDEAD_BEEF; tb_last = 1'b1; tb_valid = 1'b1;
    w = 0;
    while (!w_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1; tb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    checks++; if ({w_ready, w_rv, w_calc, w_cnt} !== {2'b10, 16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL midreset_state: got %h expected 2ffff0000", {w_ready, w_rv, w_calc, w_cnt}); end
    @(negedge clk); rst = 1'b0;
    run_frame(32'h0000_046A, sl, g, ok, er, calc, cnt, tmo);
    checks++; if ({tmo, g, ok, er, cnt} !== {4'b0110, 16'h0000}) begin
      errors++; $display("FAIL midreset_frame: got %h expected 60000", {tmo, g, ok, er, cnt}); end
  endtask

  task automatic test_bpc1();
    int sl; logic g, ok, er, tmo; logic [15:0] calc, cnt;
    sel = 2'd1;
    run_frame(32'h0000_046A, sl, g, ok, er, calc, cnt, tmo);
    checks++; if (sl !== 32) begin errors++; $display("FAIL bpc1_shift_len: got %0d expected 32", sl); end
    checks++; if ({tmo, g, ok, er, calc} !== {4'b0110, 16'h046A}) begin
      errors++; $display("FAIL bpc1_frame: got %h expected 6046a", {tmo, g, ok, er, calc}); end
  endtask

  task automatic test_bpc32();
    int sl; logic g, ok, er, tmo; logic [15:0] calc, cnt;
    sel = 2'd2;
    run_frame(32'h0000_046A, sl, g, ok, er, calc, cnt, tmo);
    checks++; if (sl !== 1) begin errors++; $display("FAIL bpc32_shift_len: got %0d expected 1", sl); end
    checks++; if ({tmo, g, ok, er, calc} !== {4'b0110, 16'h046A}) begin
      errors++; $display("FAIL bpc32_frame: got %h expected 6046a", {tmo, g, ok, er, calc}); end
  endtask

  task automatic test_saturation();
    int sl; logic g, ok, er, tmo; logic [15:0] calc, cnt;
    logic [15:0] exp_cnt [5];
    exp_cnt[0] = 16'd1; exp_cnt[1] = 16'd2; exp_cnt[2] = 16'd3; exp_cnt[3] = 16'd3; exp_cnt[4] = 16'd3;
    sel = 2'd2;
    for (int k = 0; k < 5; k++) begin
      run_frame(32'h0000_046B, sl, g, ok, er, calc, cnt, tmo);
      checks++; if ({tmo, g, ok, er} !== 4'b0101) begin errors++; $display("FAIL sat_verdict[%0d]: got %b expected 0101", k, {tmo, g, ok, er}); end
      checks++; if (cnt !== exp_cnt[k]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, cnt, exp_cnt[k]); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; sel = 2'd0;
    tb_valid = 1'b0; tb_last = 1'b0; tb_abort = 1'b0; tb_data = 32'h0000_0000;
    test_reset();
    test_good();
    test_bad();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    test_bpc1();
    test_bpc32();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc_rx_checker.md
Name: crc_rx_checker

Overview:
- Receive-side CRC-16 checker for the CAN controller data path. It is the counterpart of the 32-bit parallel transmit CRC generator.
- Consumes a frame as a stream of 32-bit payload words, then one CRC word.
- Recomputes the CRC with a bit-serial engine processing BITS_PER_CYCLE bits per clock, compares it against the received CRC, and reports pass/fail plus a saturating error count.
- Sits between the RX deserializer and the RX message buffer.

Parameters:
- BITS_PER_CYCLE, 8, bits folded into the CRC per clock; legal values 1, 2, 4, 8, 16, 32; others are a synthesis-time error.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- abort  input  1  synchronous frame abort; discards the frame in progress
- s_valid  input  1  word valid
- s_ready  output  1  checker can accept a word this cycle
- s_data  input  32  payload word, or CRC in [15:0] when the CRC word is expected
- s_last  input  1  marks the final payload word; ignored on the CRC word
- result_valid  output  1  one-cycle pulse, frame verdict available
- crc_ok  output  1  valid with result_valid; received CRC equals computed CRC
- crc_err  output  1  valid with result_valid; CRC mismatch
- crc_calc  output  16  computed CRC for the reported frame; holds until the next report
- err_count  output  CNT_W  saturating count of crc_err reports

Behaviour:
- CRC definition:
  - Polynomial x^16+x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 (0xC599, implicit x^16). Init 0xFFFF at the start of every frame. No reflection, no final XOR.
  - Galois shift, MSB-first within each word: s_data[31] is folded first, s_data[0] last.
  - Per bit: fb = crc[15] ^ d; crc = {crc[14:0],0}; if fb, crc ^= 0xC599.
  - Result must equal the transmit parallel generator word-for-word.
- Reset values: state DATA, s_ready=1, result_valid=0, crc_ok=0, crc_err=0, crc_calc=0xFFFF, err_count=0, internal crc=0xFFFF.
- FSM states:
  - DATA: s_ready=1. On s_valid&s_ready, latch s_data into the shift register, latch s_last, load beat counter N=32/BITS_PER_CYCLE, go to SHIFT.
  - SHIFT: s_ready=0. Each cycle, fold the top BITS_PER_CYCLE bits of the shift register into crc, shift the register left, decrement the counter. After N cycles go to WAIT_CRC if the latched last=1, else DATA.
  - WAIT_CRC: s_ready=1. On s_valid&s_ready, compare s_data[15:0] with crc and register the result. s_data[31:16] is ignored. Go to REPORT.
  - REPORT: s_ready=0. result_valid=1 for exactly this cycle. crc_ok/crc_err are mutually exclusive. crc_calc is updated. err_count increments on mismatch and saturates at all-ones. crc is reinitialised to 0xFFFF. Next state is DATA.
- Latency:
  - A payload word accepted at edge t: s_ready reasserts at edge t+N.
  - A CRC word accepted at edge t: result_valid is high in the cycle after edge t.
  - Throughput is one payload word per N+1 cycles.
- crc_ok and crc_err are 0 whenever result_valid=0.
- abort:
  - When asserted, s_ready is forced to 0 that cycle; a coincident s_valid is not accepted.
  - Next edge: state DATA, crc=0xFFFF, no result_valid for the aborted frame.
  - err_count and crc_calc are unchanged.
  - Abort in REPORT still completes the pulse already in progress, then the FSM returns to DATA.
- s_valid while s_ready=0: no effect. The source must hold data stable until accepted.
- Reset mid-frame clears all state, including err_count. The partial frame produces no report.

Test Plan:
- Reset (BITS_PER_CYCLE=8): assert then release rst -> s_ready=1, result_valid=0, crc_calc=0xFFFF, err_count=0.
- Good frame (BITS_PER_CYCLE=8):
  - Stimulus: word 0x00000000 with s_last=1, then CRC word 0x0000046A.
  - Response: s_ready low exactly 4 cycles after the payload handshake; one-cycle result_valid with crc_ok=1, crc_err=0, crc_calc=0x046A, err_count=0.
- Bad frame: same payload, CRC word 0xABCD046B -> crc_err=1, crc_ok=0, crc_calc=0x046A, err_count=1. Repeat with CRC word 0xFFFF046A -> crc_ok=1; upper bits are ignored.
- Back-to-back with s_valid held high:
  - Stimulus: two identical good frames (0x00000000 then 0x0000046A) with no idle gap.
  - Response: both report crc_ok=1; second frame starts from 0xFFFF; s_ready low during every SHIFT and REPORT cycle.
- Abort:
  - Stimulus: two-word frame with abort pulsed during SHIFT of word 1, then a fresh good single-word frame.
  - Response: no result_valid for the aborted frame; fresh frame reports crc_ok=1, crc_calc=0x046A.
- Widths and saturation:
  - BITS_PER_CYCLE=1 and 32: good frame yields crc_calc=0x046A with SHIFT lengths 32 and 1 cycles respectively.
  - CNT_W=2: five bad frames -> err_count sequence 1, 2, 3, 3, 3.
